// File: rtl/gf180mcu_fd_sc_mcu7t5v0__aoi_pipe.sv
// gf180mcu_fd_sc_mcu7t5v0__aoi_pipe
// Pipelined, parametrised AND-OR-INVERT evaluator with valid/ready handshake.
// Per lane: ZN[l] = ~( OR_g( AND_b A[l,g,b] ) | OR_s C[l,s] ).
// Optional feature macro: GF180MCU_AOI_PIPE_STAGE1_EN
//   defined   -> term register (S1) + result register (S2), latency 2, capacity 2
//   undefined -> result register (S2) only, latency 1, capacity 1
// Reset (RST) is asynchronous and active-high.

module gf180mcu_fd_sc_mcu7t5v0__aoi_pipe #(
  parameter int LANES = 1,
  parameter int NGRP  = 2,
  parameter int GW    = 2,
  parameter int NSGL  = 1
) (
  input  logic                      CLK,
  input  logic                      RST,
  inout  wire                       VDD,
  inout  wire                       VSS,
  input  logic [LANES*NGRP*GW-1:0]  A,
  input  logic [LANES*NSGL-1:0]     C,
  input  logic                      IVALID,
  output logic                      IREADY,
  output logic [LANES-1:0]          ZN,
  output logic                      OVALID,
  input  logic                      OREADY
);

  // Term vector per lane: one AND result per group, plus the OR of the singles.
  localparam int TW = NGRP + 1;

  // Supply pins carry no logic; they are only tied off here.
  wire unused_supply = VDD ^ VSS;

  logic [LANES-1:0][TW-1:0] term_d;
  logic [LANES-1:0][TW-1:0] term_s2;   // terms feeding the result stage
  logic                     in_xfer;
  logic                     s2_load;
  logic                     s2_valid_q, s2_valid_d;
  logic [LANES-1:0]         zn_q, zn_d;

  // Reduce raw inputs to the per-lane term vector.
  always_comb begin
    // NOTE: every combinationally assigned signal gets a default first so no path leaves it unassigned (no latch).
    term_d = '0;
    for (int l = 0; l < LANES; l++) begin
      for (int g = 0; g < NGRP; g++) begin
        term_d[l][g] = &A[(l*NGRP+g)*GW +: GW];
      end
      term_d[l][NGRP] = |C[l*NSGL +: NSGL];
    end
  end

`ifdef GF180MCU_AOI_PIPE_STAGE1_EN
  logic [LANES-1:0][TW-1:0] term_q;
  logic                     s1_valid_q, s1_valid_d;

  // S1 frees up whenever it is empty, or its contents can move into S2 this cycle.
  assign IREADY  = ~RST & (~s1_valid_q | ~s2_valid_q | OREADY);
  assign in_xfer = IVALID & IREADY;
  assign s2_load = s1_valid_q & (~s2_valid_q | OREADY);
  assign term_s2 = term_q;

  // S1 occupancy: a new input refills it, a move into S2 empties it.
  always_comb begin
    s1_valid_d = in_xfer | (s1_valid_q & ~s2_load);
  end

  // S1 register: captures the term vector on every input transfer.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      // NOTE: registers use non-blocking assignments so all flops update from pre-edge values.
      s1_valid_q <= 1'b0;
      term_q     <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      if (in_xfer) begin
        term_q <= term_d;
      end
    end
  end
`else
  // Without S1 the result register is the only buffer.
  assign IREADY  = ~RST & (~s2_valid_q | OREADY);
  assign in_xfer = IVALID & IREADY;
  assign s2_load = in_xfer;
  assign term_s2 = term_d;
`endif

  // Final NOR of each lane's term vector, plus S2 occupancy.
  always_comb begin
    zn_d = '1;
    for (int l = 0; l < LANES; l++) begin
      zn_d[l] = ~|term_s2[l];
    end
    s2_valid_d = s2_load | (s2_valid_q & ~OREADY);
  end

  // S2 register: holds the result stable while the consumer stalls.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      s2_valid_q <= 1'b0;
      zn_q       <= '1;   // AOI of all-zero inputs
    end else begin
      s2_valid_q <= s2_valid_d;
      if (s2_load) begin
        zn_q <= zn_d;
      end
    end
  end

  assign ZN     = zn_q;
  assign OVALID = s2_valid_q;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__aoi_pipe.sv
// Testbench for gf180mcu_fd_sc_mcu7t5v0__aoi_pipe.
// Two instances run in lockstep on shared handshake controls: the default
// aoi221-shaped lane and a LANES=4, NGRP=3, GW=3, NSGL=2 instance.
// The reference is a transaction queue: each accepted item records its
// expected results and acceptance edge; visibility follows from latency and
// readiness from queue occupancy against capacity.

module tb_gf180mcu_fd_sc_mcu7t5v0__aoi_pipe;

`ifdef GF180MCU_AOI_PIPE_STAGE1_EN
  localparam int LAT = 2;
  localparam int CAP = 2;
`else
  localparam int LAT = 1;
  localparam int CAP = 1;
`endif

  typedef struct {
    int         t;
    logic       zn0;
    logic [3:0] zn1;
  } item_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        ivalid, oready;
  logic [3:0]  a0;
  logic [0:0]  c0;
  logic [35:0] a1;
  logic [7:0]  c1;
  logic        ir0, ov0, ir1, ov1;
  logic [0:0]  zn0;
  logic [3:0]  zn1;
  wire         vdd, vss;

  assign vdd = 1'b1;
  assign vss = 1'b0;

  always #5 clk = ~clk;

  gf180mcu_fd_sc_mcu7t5v0__aoi_pipe u_dut0 (
    .CLK(clk), .RST(rst), .VDD(vdd), .VSS(vss),
    .A(a0), .C(c0), .IVALID(ivalid), .IREADY(ir0),
    .ZN(zn0), .OVALID(ov0), .OREADY(oready)
  );

  gf180mcu_fd_sc_mcu7t5v0__aoi_pipe #(.LANES(4), .NGRP(3), .GW(3), .NSGL(2)) u_dut1 (
    .CLK(clk), .RST(rst), .VDD(vdd), .VSS(vss),
    .A(a1), .C(c1), .IVALID(ivalid), .IREADY(ir1),
    .ZN(zn1), .OVALID(ov1), .OREADY(oready)
  );

  int    checks = 0;
  int    errors = 0;
  int    edge_cnt = 0;
  int    accepted = 0;
  int    popped = 0;
  logic  last_acc = 1'b0;
  logic  use_dir = 1'b0;
  logic  dir_zn = 1'b0;
  item_t q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // aoi221: ~((A1&A2)|(B1&B2)|C)
  function automatic logic ref0(input logic [3:0] a, input logic [0:0] c);
    return ~((a[0] & a[1]) | (a[2] & a[3]) | c[0]);
  endfunction

  // Wide configuration: a lane is low if any 3-bit group is all ones or any single is set.
  function automatic logic [3:0] ref1(input logic [35:0] a, input logic [7:0] c);
    logic [3:0] z;
    bit         hit;
    z = '0;
    for (int l = 0; l < 4; l++) begin
      hit = (c[l*2 +: 2] != 2'b00);
      for (int g = 0; g < 3; g++) begin
        if (a[(l*3+g)*3 +: 3] == 3'b111) hit = 1'b1;
      end
      z[l] = !hit;
    end
    return z;
  endfunction

  task automatic rand_in();
    a0 = 4'($urandom);
    c0 = 1'($urandom);
    a1 = 36'({$urandom, $urandom} | {$urandom, $urandom});
    c1 = 8'($urandom & $urandom & $urandom);
  endtask

  // One clock: check outputs at the falling edge, then advance the model at the rising edge.
  task automatic cycle();
    logic  eov, eir, acc, pop;
    item_t it;
    @(negedge clk);
    eov = (q.size() > 0) && ((edge_cnt - q[0].t) >= (LAT - 1));
    eir = (q.size() < CAP) || oready;
    check("iready0", 64'(ir0), 64'(eir));
    check("iready1", 64'(ir1), 64'(eir));
    check("ovalid0", 64'(ov0), 64'(eov));
    check("ovalid1", 64'(ov1), 64'(eov));
    if (eov) begin
      check("zn0", 64'(zn0), 64'(q[0].zn0));
      check("zn1", 64'(zn1), 64'(q[0].zn1));
    end
    acc    = ivalid && eir;
    pop    = eov && oready;
    it.t   = 0;
    it.zn0 = use_dir ? dir_zn : ref0(a0, c0);
    it.zn1 = ref1(a1, c1);
    @(posedge clk);
    edge_cnt++;
    if (pop) begin
      void'(q.pop_front());
      popped++;
    end
    if (acc) begin
      it.t = edge_cnt;
      q.push_back(it);
      accepted++;
    end
    last_acc = acc;
    #1;
  endtask

  task automatic drain();
    ivalid = 1'b0;
    oready = 1'b1;
    for (int i = 0; i < 10 && q.size() > 0; i++) cycle();
    check("drain_empty", 64'(q.size()), 64'(0));
  endtask

  logic [3:0] dir_a [4] = '{4'b0000, 4'b0011, 4'b0101, 4'b0000};
  logic       dir_c [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
  logic       dir_z [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
  logic [3:0] bp_a  [3] = '{4'b0011, 4'b0000, 4'b0000};
  logic       bp_c  [3] = '{1'b0, 1'b0, 1'b1};
  logic       bp_z  [3] = '{1'b0, 1'b1, 1'b0};

  initial begin
    int base;
    int k;
    rst = 1'b1; ivalid = 1'b0; oready = 1'b0;
    a0 = '0; c0 = '0; a1 = '0; c1 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_iready0", 64'(ir0), 64'(0));
    check("rst_iready1", 64'(ir1), 64'(0));
    check("rst_ovalid0", 64'(ov0), 64'(0));
    check("rst_ovalid1", 64'(ov1), 64'(0));
    check("rst_zn0", 64'(zn0), 64'(1));
    check("rst_zn1", 64'(zn1), 64'(4'hf));
    rst = 1'b0;
    #1;
    check("post_rst_iready", 64'(ir0), 64'(1));

    // Directed aoi221 vectors with known results.
    oready  = 1'b1;
    use_dir = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rand_in();
      ivalid = 1'b1;
      a0 = dir_a[i]; c0 = dir_c[i]; dir_zn = dir_z[i];
      cycle();
    end
    use_dir = 1'b0;
    drain();

    // Exhaustive 5-bit input space of the default lane, back to back.
    for (int i = 0; i < 32; i++) begin
      rand_in();
      ivalid = 1'b1;
      {a0, c0} = 5'(i);
      cycle();
    end
    drain();

    // Backpressure: three distinct inputs against a stalled consumer.
    use_dir = 1'b1;
    oready  = 1'b0;
    ivalid  = 1'b1;
    k = 0;
    rand_in();
    a0 = bp_a[0]; c0 = bp_c[0]; dir_zn = bp_z[0];
    base = accepted;
    for (int i = 0; i < 5; i++) begin
      cycle();
      if (last_acc && k < 2) begin
        k++;
        rand_in();
        a0 = bp_a[k]; c0 = bp_c[k]; dir_zn = bp_z[k];
      end
    end
    check("bp_accepted", 64'(accepted - base), 64'(CAP));
    oready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cycle();
      if (last_acc && k < 2) begin
        k++;
        rand_in();
        a0 = bp_a[k]; c0 = bp_c[k]; dir_zn = bp_z[k];
      end else if (last_acc) begin
        ivalid = 1'b0;
      end
    end
    use_dir = 1'b0;
    drain();
    check("bp_all_out", 64'(accepted - base), 64'(3));

    // Streaming: 100 back-to-back transactions with the consumer always ready.
    base = popped;
    oready = 1'b1;
    ivalid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      rand_in();
      cycle();
    end
    drain();
    check("stream_count", 64'(popped - base), 64'(100));

    // Random valid/ready traffic; inputs held until accepted.
    ivalid = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (!ivalid || last_acc) begin
        rand_in();
        ivalid = ($urandom_range(3) != 0);
      end
      oready = ($urandom_range(2) != 0);
      cycle();
    end
    drain();
    check("rand_no_loss", 64'(accepted), 64'(popped));

    // Reset with transactions in flight.
    oready = 1'b0;
    ivalid = 1'b1;
    rand_in();
    for (int i = 0; i < 4 && q.size() < CAP; i++) begin
      cycle();
      rand_in();
    end
    ivalid = 1'b0;
    check("mid_inflight", 64'(q.size()), 64'(CAP));
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_ovalid0", 64'(ov0), 64'(0));
    check("mid_rst_ovalid1", 64'(ov1), 64'(0));
    check("mid_rst_zn0", 64'(zn0), 64'(1));
    check("mid_rst_zn1", 64'(zn1), 64'(4'hf));
    check("mid_rst_iready", 64'(ir0), 64'(0));
    q.delete();
    @(posedge clk);
    #1;
    check("mid_rst_hold_iready", 64'(ir1), 64'(0));
    rst = 1'b0;
    #1;
    check("mid_rel_iready", 64'(ir0), 64'(1));
    oready = 1'b1;
    repeat (4) cycle();
    for (int i = 0; i < 6; i++) begin
      rand_in();
      ivalid = 1'b1;
      cycle();
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
